// File: rtl/hwpf_pkg.sv
// rtl/hwpf_pkg.sv - shared types and helpers for the prefetch issue arbiter
//
// Contents:
//   req_cpu_dcache_t : default demand/prefetch request payload
//   hwpf_state_e     : arbiter FSM states IDLE, FETCH, ISSUE
//   inflight_w()     : width of a counter able to hold 0..max_inflight
package hwpf_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
  } req_cpu_dcache_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } hwpf_state_e;

  // A zero-sized bound would give a zero-width vector, so clamp to one bit.
  function automatic int unsigned inflight_w(input int unsigned max_inflight);
    return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/hwpf_credit_counter.sv
// rtl/hwpf_credit_counter.sv - saturating outstanding-prefetch credit counter
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : one prefetch accepted by the dcache
//   dec_i         : one prefetch response returned
//   count_o       : outstanding count, 0..MAX_CNT
//   full_o        : count_o == MAX_CNT
module hwpf_credit_counter
  import hwpf_pkg::*;
#(
  parameter int unsigned MAX_CNT = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           inc_i,
  input  logic                           dec_i,
  output logic [inflight_w(MAX_CNT)-1:0] count_o,
  output logic                           full_o
);

  localparam int unsigned CW = inflight_w(MAX_CNT);
  localparam logic [CW-1:0] MAX_VAL = CW'(MAX_CNT);

  logic [CW-1:0] r_count;
  logic          w_inc_ok;
  logic          w_dec_ok;

  // A simultaneous inc and dec cancel; both ends saturate.
  assign w_inc_ok = inc_i & ~dec_i & (r_count != MAX_VAL);
  assign w_dec_ok = dec_i & ~inc_i & (r_count != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (w_inc_ok) begin
      r_count <= r_count + CW'(1);
    end else if (w_dec_ok) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign count_o = r_count;
  assign full_o  = (r_count == MAX_VAL);

endmodule

// File: rtl/hwpf_issue_arbiter.sv
// rtl/hwpf_issue_arbiter.sv - arbitrates demand and hardware-prefetch requests onto one dcache port
//
// Optional feature macro: HWPF_ARB_STATS_EN (32-bit accepted-prefetch counter on stat_pf_issued_o).
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : pipeline flush, drops any prefetch in progress
//   cpu_req_valid_i/_i     : demand request (always wins the port)
//   cpu_req_ready_o        : demand accepted (pass-through of dcache_ready_i)
//   pf_read_o              : one-cycle pop pulse to the prefetch FIFO
//   pf_valid_i, pf_req_i   : FIFO head, one cycle after pf_read_o
//   pf_lock_o              : freezes the FIFO while credits are exhausted
//   dcache_req_valid_o/_o  : muxed request to the dcache
//   dcache_req_is_pf_o     : the driven request is the prefetch
//   dcache_ready_i         : dcache accepts this cycle
//   dcache_rsp_valid_i     : dcache response valid
//   dcache_rsp_is_pf_i     : response belongs to a prefetch
//   pf_inflight_o          : outstanding prefetch count
//   stat_pf_issued_o       : accepted prefetch count (0 without the macro)
module hwpf_issue_arbiter
  import hwpf_pkg::*;
#(
  parameter int unsigned MAX_PF_INFLIGHT = 4,
  parameter int unsigned PF_GAP          = 2,
  parameter type         cpu_addr_t      = req_cpu_dcache_t
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   cpu_req_valid_i,
  input  cpu_addr_t                              cpu_req_i,
  output logic                                   cpu_req_ready_o,
  output logic                                   pf_read_o,
  input  logic                                   pf_valid_i,
  input  cpu_addr_t                              pf_req_i,
  output logic                                   pf_lock_o,
  output logic                                   dcache_req_valid_o,
  output cpu_addr_t                              dcache_req_o,
  output logic                                   dcache_req_is_pf_o,
  input  logic                                   dcache_ready_i,
  input  logic                                   dcache_rsp_valid_i,
  input  logic                                   dcache_rsp_is_pf_i,
  output logic [inflight_w(MAX_PF_INFLIGHT)-1:0] pf_inflight_o,
  output logic [31:0]                            stat_pf_issued_o
);

  localparam int unsigned QW = (PF_GAP < 1) ? 1 : $clog2(PF_GAP + 1);
  localparam logic [QW-1:0] GAP_VAL = QW'(PF_GAP);

  hwpf_state_e   r_state;
  hwpf_state_e   w_state_nxt;
  cpu_addr_t     r_hold;
  cpu_addr_t     w_hold_nxt;
  logic [QW-1:0] r_quiet;
  logic          w_full;
  logic          w_in_issue;
  logic          w_pf_drive;
  logic          w_pf_hs;
  logic          w_pf_rsp;

  // Counts consecutive CPU-idle cycles, saturating at the gap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_quiet <= '0;
    end else if (flush_i || cpu_req_valid_i) begin
      r_quiet <= '0;
    end else if (r_quiet != GAP_VAL) begin
      r_quiet <= r_quiet + QW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    pf_read_o   = 1'b0;
    if (flush_i) begin
      w_state_nxt = IDLE;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((r_quiet == GAP_VAL) && !w_full && !cpu_req_valid_i) begin
            pf_read_o   = 1'b1;
            w_state_nxt = FETCH;
          end
        end
        FETCH: begin
          // An empty FIFO answers the pop with pf_valid_i low.
          if (pf_valid_i) begin
            w_hold_nxt  = pf_req_i;
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        ISSUE: begin
          // While the CPU owns the port the hold register simply waits.
          if (w_pf_hs) begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_in_issue = (r_state == ISSUE);
  assign w_pf_drive = w_in_issue & ~cpu_req_valid_i & ~flush_i;
  assign w_pf_hs    = w_pf_drive & dcache_ready_i;
  assign w_pf_rsp   = dcache_rsp_valid_i & dcache_rsp_is_pf_i;

  assign dcache_req_valid_o = cpu_req_valid_i | (w_in_issue & ~flush_i);
  assign dcache_req_o       = w_pf_drive ? r_hold : cpu_req_i;
  assign dcache_req_is_pf_o = w_pf_drive;
  assign cpu_req_ready_o    = dcache_ready_i;
  assign pf_lock_o          = w_full;

  hwpf_credit_counter #(
    .MAX_CNT(MAX_PF_INFLIGHT)
  ) u_credit (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_pf_hs),
    .dec_i  (w_pf_rsp),
    .count_o(pf_inflight_o),
    .full_o (w_full)
  );

`ifdef HWPF_ARB_STATS_EN
  logic [31:0] r_stat;

  // Wraps naturally; a flush does not clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat <= '0;
    end else if (w_pf_hs) begin
      r_stat <= r_stat + 32'd1;
    end
  end

  assign stat_pf_issued_o = r_stat;
`else
  assign stat_pf_issued_o = '0;
`endif

endmodule
